dmem_copy: RTL and testbench
============================

# dmem_copy

Block-copy engine that acts as the initiator on the data-memory port. It drives `memWrite`, `addr` and `writeData` and consumes `readData`. On a start pulse it copies `len` consecutive 32-bit words from a source byte address to a destination byte address, then reports completion. It sits between the control logic and `dmem`, muxed onto the memory port when `busy` is high.

## Interface
- `n`, default 32: data and address width in bits.
- `r`, default 7: width of the word-count input; maximum copy is 2^r−1 words.

Ports:
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: reset, synchronous, active-high.
- `start`  input  1: one-cycle request; sampled only in IDLE.
- `srcAddr`  input  n: source byte address; bits [1:0] are ignored (treated as 0).
- `dstAddr`  input  n: destination byte address; bits [1:0] are ignored.
- `len`  input  r: number of words to copy.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: one-cycle completion pulse.
- `memWrite`  output  1: write strobe to dmem.
- `addr`  output  n: address to dmem.
- `writeData`  output  n: write data to dmem.
- `readData`  input  n: dmem read data, combinational from `addr`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `start`=1 latches `srcAddr`&~3, `dstAddr`&~3 and `len` into srcPtr, dstPtr and remaining.
  - Next state is READ if `len`≠0, otherwise DONE.
- READ:
  - `addr`=srcPtr, `memWrite`=0.
  - At the clock edge, the word buffer captures `readData` and srcPtr += 4.
  - Next state is WRITE.
- WRITE:
  - `addr`=dstPtr, `writeData`=word buffer, `memWrite`=1.
  - At the clock edge, dstPtr += 4 and remaining −= 1.
  - Next state is READ if remaining≠1, otherwise DONE.
- DONE: `done`=1, `busy`=1; next state is IDLE.
- Pointers wrap modulo 2^n; wrap-around is silent and no error is flagged.
- Copy order is ascending (forward). Overlapping regions with dst>src propagate copied data. This is the defined behaviour; callers must avoid such overlaps.
- `start` is ignored outside IDLE. Inputs are not sampled again until the next IDLE.
- `rst` forces IDLE at the edge and clears pointers, remaining, word buffer and checksum.
- `memWrite` is combinationally gated by `!rst`, so a reset asserted during WRITE prevents that write.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `memWrite`=0.
  - `addr`=0, `writeData`=0.
  - `checksum`=0 (when compiled in).
- Taking the start-sampling edge as edge 0:
  - READ occupies cycle 1 and WRITE occupies cycle 2.
  - Word k (0-based) is read in cycle 2k+1 and written in cycle 2k+2.
  - DONE is in cycle 2·len+1; IDLE returns in cycle 2·len+2.
- Throughput is 2 cycles per word. For `len`=0, DONE is in cycle 1.
- In IDLE, `addr`=0 and `writeData`=0.
- A new `start` is accepted in the first IDLE cycle after DONE. Back-to-back copies therefore have a 1-cycle gap.

## Configuration
- Macro: `DMEM_COPY_CHECKSUM_EN`.
- Defined:
  - Adds output port `checksum` (n bits).
  - The accumulator clears on accepted `start` and adds each written word mod 2^n in the WRITE cycle.
  - The value is valid and stable from DONE until the next accepted `start`.
- Undefined: no port and no accumulator logic. All other behaviour is identical.

## Structure
- Package `dmem_copy_pkg` contains:
  - state enum `copy_state_t` {IDLE, READ, WRITE, DONE};
  - constant `WORD_BYTES`=4.
- Single module with no sub-module. The FSM, pointers, counter and buffer are small enough to stay flat.
- Verification uses the existing `dmem` and `clock` modules as the memory model and clock source.

## Test plan
- Single word: preload mem[0x54]=32'hDEADBEEF; start with src=0x54, dst=0xA8, len=1.
  - `memWrite` is high only in cycle 2 with `addr`=0xA8.
  - `done` is high in cycle 3; mem[0xA8] reads back DEADBEEF.
- Block copy: preload 0x00..0x0C = 1,2,3,4; copy to 0x40 with len=4.
  - 0x40..0x4C = 1,2,3,4; `done` in cycle 9.
  - With the macro defined, `checksum`=32'hA.
- Zero length: len=0.
  - `memWrite` never asserts; `done` in cycle 1; `busy` is high only in cycle 1.
- Ignored start and alignment: pulse `start` during an active copy, and use src=0x57.
  - The second request has no effect.
  - The copy reads from 0x54.
- Reset mid-operation: assert `rst` in the cycle of word 1's WRITE in a len=4 copy.
  - The destination word 1 is unchanged.
  - All outputs are 0 next cycle; state is IDLE.
- Wrap-around: src=32'hFFFFFFFC, len=2.
  - The second read is at `addr`=0x0.

Source files
------------

// File: rtl/dmem_copy_pkg.sv
// dmem_copy_pkg: shared types and constants for the dmem_copy block-copy engine.
//   copy_state_t : FSM state encoding {IDLE, READ, WRITE, DONE}
//   WORD_BYTES   : byte stride between consecutive 32-bit words
package dmem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_copy.sv
// dmem_copy: block-copy engine acting as initiator on the data-memory port.
// Copies len consecutive words from srcAddr to dstAddr (both word-aligned
// by dropping bits [1:0]), two cycles per word (READ then WRITE), then
// pulses done for one cycle.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   srcAddr, dstAddr    source / destination byte addresses (n bits)
//   len                 word count (r bits), 0 goes straight to DONE
//   busy, done          busy in every non-IDLE state, done pulse in DONE
//   memWrite, addr,
//   writeData           dmem request outputs
//   readData            dmem read data, combinational from addr
//   checksum            (only with `DMEM_COPY_CHECKSUM_EN) sum of words written
//
// Optional feature macro: DMEM_COPY_CHECKSUM_EN
module dmem_copy
  import dmem_copy_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] srcAddr,
  input  logic [n-1:0] dstAddr,
  input  logic [r-1:0] len,
  output logic         busy,
  output logic         done,
  output logic         memWrite,
  output logic [n-1:0] addr,
  output logic [n-1:0] writeData,
  input  logic [n-1:0] readData
`ifdef DMEM_COPY_CHECKSUM_EN
  ,
  output logic [n-1:0] checksum
`endif
);

  localparam logic [n-1:0] STRIDE     = n'(WORD_BYTES);
  localparam logic [n-1:0] ALIGN_MASK = ~n'(WORD_BYTES - 1);

  copy_state_t state, state_next;

  logic [n-1:0] srcPtr;
  logic [n-1:0] dstPtr;
  logic [r-1:0] remaining;
  logic [n-1:0] wordBuf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (len != '0) ? READ : DONE;
      READ:  state_next = WRITE;
      WRITE: state_next = (remaining != r'(1)) ? READ : DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; memWrite is gated by rst so a reset in WRITE suppresses the store
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    memWrite  = (state == WRITE) && !rst;
    addr      = '0;
    writeData = '0;
    unique case (state)
      READ:  addr = srcPtr;
      WRITE: begin
        addr      = dstPtr;
        writeData = wordBuf;
      end
      default: ;
    endcase
  end

  // Datapath: pointers, word counter, word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      srcPtr    <= '0;
      dstPtr    <= '0;
      remaining <= '0;
      wordBuf   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          srcPtr    <= srcAddr & ALIGN_MASK;
          dstPtr    <= dstAddr & ALIGN_MASK;
          remaining <= len;
        end
        READ: begin
          wordBuf <= readData;
          srcPtr  <= srcPtr + STRIDE;
        end
        WRITE: begin
          dstPtr    <= dstPtr + STRIDE;
          remaining <= remaining - r'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_COPY_CHECKSUM_EN
  // Cleared on an accepted start, accumulates each word as it is written
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + wordBuf;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_copy.sv
// tb_dmem_copy: directed self-checking bench for dmem_copy with a small
// word-addressed memory model (256 words, index addr[9:2]).
module tb_dmem_copy;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] srcAddr;
  logic [31:0] dstAddr;
  logic [6:0]  len;
  logic        busy;
  logic        done;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  dmem_copy #(.n(32), .r(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData)
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign readData = mem[addr[9:2]];

  always @(posedge clk) begin
    if (memWrite) mem[addr[9:2]] <= writeData;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; srcAddr = '0; dstAddr = '0; len = '0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;

    // Reset state
    cyc(); cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_writeData", writeData, 32'h0);
    rst = 1'b0;
    mem[8'h54 >> 2] <= 32'hDEADBEEF;
    cyc();

    // Single word copy 0x54 -> 0xA8
    srcAddr = 32'h54; dstAddr = 32'hA8; len = 7'd1; start = 1'b1;
    cyc(); start = 1'b0;                                   // cycle 1
    check("w1_c1_busy", 32'(busy), 32'd1);
    check("w1_c1_memWrite", 32'(memWrite), 32'd0);
    check("w1_c1_addr", addr, 32'h54);
    cyc();                                                 // cycle 2
    check("w1_c2_memWrite", 32'(memWrite), 32'd1);
    check("w1_c2_addr", addr, 32'hA8);
    check("w1_c2_wdata", writeData, 32'hDEADBEEF);
    cyc();                                                 // cycle 3
    check("w1_c3_done", 32'(done), 32'd1);
    check("w1_c3_memWrite", 32'(memWrite), 32'd0);
    cyc();                                                 // cycle 4
    check("w1_c4_busy", 32'(busy), 32'd0);
    check("w1_c4_done", 32'(done), 32'd0);
    check("w1_mem", mem[8'hA8 >> 2], 32'hDEADBEEF);

    // Block copy 0x00..0x0C -> 0x40..0x4C
    for (int i = 0; i < 4; i++) mem[i] <= 32'(i + 1);
    cyc();
    srcAddr = 32'h0; dstAddr = 32'h40; len = 7'd4; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc(); start = 1'b0;
      check($sformatf("blk_c%0d_done", c), 32'(done), 32'(c == 9));
      check($sformatf("blk_c%0d_memWrite", c), 32'(memWrite), 32'((c % 2 == 0) && (c <= 8)));
      if (c % 2 == 0 && c <= 8)
        check($sformatf("blk_c%0d_addr", c), addr, 32'h40 + 32'(4 * (c / 2 - 1)));
    end
    cyc();
    check("blk_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("blk_mem%0d", i), mem[16 + i], 32'(i + 1));
`ifdef DMEM_COPY_CHECKSUM_EN
    check("blk_checksum", checksum, 32'hA);
`endif

    // Zero length
    srcAddr = 32'h0; dstAddr = 32'h40; len = 7'd0; start = 1'b1;
    cyc(); start = 1'b0;
    check("z_c1_done", 32'(done), 32'd1);
    check("z_c1_busy", 32'(busy), 32'd1);
    check("z_c1_memWrite", 32'(memWrite), 32'd0);
    cyc();
    check("z_c2_busy", 32'(busy), 32'd0);
    check("z_c2_done", 32'(done), 32'd0);
    check("z_c2_memWrite", 32'(memWrite), 32'd0);

    // Misaligned source, ignored start during copy
    mem[8'h58 >> 2] <= 32'h11111111;
    cyc();
    srcAddr = 32'h57; dstAddr = 32'h80; len = 7'd2; start = 1'b1;
    cyc(); start = 1'b0;                                   // cycle 1
    check("al_c1_addr", addr, 32'h54);
    cyc();                                                 // cycle 2
    srcAddr = 32'h0; dstAddr = 32'hC0; len = 7'd1; start = 1'b1;
    cyc(); start = 1'b0;                                   // cycle 3
    check("al_c3_addr", addr, 32'h58);
    cyc();                                                 // cycle 4
    check("al_c4_addr", addr, 32'h84);
    cyc();                                                 // cycle 5
    check("al_c5_done", 32'(done), 32'd1);
    cyc();                                                 // cycle 6
    check("al_c6_busy", 32'(busy), 32'd0);
    check("al_mem0", mem[8'h80 >> 2], 32'hDEADBEEF);
    check("al_mem1", mem[8'h84 >> 2], 32'h11111111);
    check("al_ignored", mem[8'hC0 >> 2], 32'h0);

    // Reset during word 1's WRITE
    for (int i = 0; i < 4; i++) begin
      mem[64 + i]  <= 32'hA0 + 32'(i);
      mem[128 + i] <= 32'h55;
    end
    cyc();
    srcAddr = 32'h100; dstAddr = 32'h200; len = 7'd4; start = 1'b1;
    cyc(); start = 1'b0;                                   // cycle 1
    cyc(); cyc(); cyc();                                   // cycle 4 (WRITE word 1)
    check("rm_c4_addr", addr, 32'h204);
    rst = 1'b1;
    #1;
    check("rm_gated_memWrite", 32'(memWrite), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_done", 32'(done), 32'd0);
    check("rm_memWrite", 32'(memWrite), 32'd0);
    check("rm_addr", addr, 32'h0);
    check("rm_writeData", writeData, 32'h0);
    cyc();
    check("rm_stay_idle", 32'(busy), 32'd0);
    check("rm_mem0", mem[128], 32'hA0);
    check("rm_mem1", mem[129], 32'h55);

    // Source pointer wrap-around
    mem[255] <= 32'h77;
    cyc();
    srcAddr = 32'hFFFFFFFC; dstAddr = 32'h300; len = 7'd2; start = 1'b1;
    cyc(); start = 1'b0;                                   // cycle 1
    check("wr_c1_addr", addr, 32'hFFFFFFFC);
    cyc(); cyc();                                          // cycle 3
    check("wr_c3_addr", addr, 32'h0);
    check("wr_c3_memWrite", 32'(memWrite), 32'd0);
    cyc();                                                 // cycle 4
    check("wr_c4_addr", addr, 32'h304);
    cyc();                                                 // cycle 5
    check("wr_c5_done", 32'(done), 32'd1);
    cyc();
    check("wr_mem0", mem[192], 32'h77);
    check("wr_mem1", mem[193], 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
